// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the execute-stage CCR controller: ALU op codes, flag bit
// positions, jump types, FSM states and the per-op flag merge helper.
package alu_ctrl_pkg;

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_NOT  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_LDM  = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_INC  = 4'b0111;
   localparam logic [3:0] OP_DEC  = 4'b1000;
   localparam logic [3:0] OP_CLRC = 4'b1001;
   localparam logic [3:0] OP_SETC = 4'b1010;
   localparam logic [3:0] OP_SHL  = 4'b1011;
   localparam logic [3:0] OP_SHR  = 4'b1100;
   localparam logic [3:0] OP_IN   = 4'b1111;

   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_Z = 0;

   localparam logic [1:0] BR_JZ  = 2'b00;
   localparam logic [1:0] BR_JN  = 2'b01;
   localparam logic [1:0] BR_JC  = 2'b10;
   localparam logic [1:0] BR_JMP = 2'b11;

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_FREEZE = 1'b1
   } ccr_state_t;

   // Apply one ALU op's flag effect to the current {N,C,Z}.
   function automatic logic [2:0] merge_flags(input logic [2:0] cur,
                                              input logic [3:0] op,
                                              input logic [2:0] flg);
      logic [2:0] res;
      res = cur;
      case (op)
         OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_SHL, OP_SHR: res = flg;
         OP_NOT, OP_AND, OP_OR: begin
            res[FLAG_N] = flg[FLAG_N];
            res[FLAG_Z] = flg[FLAG_Z];
         end
         OP_SETC: res[FLAG_C] = 1'b1;
         OP_CLRC: res[FLAG_C] = 1'b0;
         default: res = cur;
      endcase
      return res;
   endfunction

   // Flag bit examined by a conditional jump type.
   function automatic logic [1:0] tested_bit(input logic [1:0] br_type);
      logic [1:0] idx;
      case (br_type)
         BR_JZ:   idx = 2'(FLAG_Z);
         BR_JN:   idx = 2'(FLAG_N);
         BR_JC:   idx = 2'(FLAG_C);
         default: idx = 2'(FLAG_Z);
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/ccr_shadow_stack.sv
// LIFO of saved {N,C,Z} values for nested interrupts. Overflowing pushes are dropped,
// underflowing pops leave state alone; both set a sticky error cleared only by reset.
module ccr_shadow_stack #(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   input  logic [2:0] din,
   output logic [2:0] dout,
   output logic       empty,
   output logic       full,
   output logic       err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [2:0]    mem_r [DEPTH];
   logic [CW-1:0] cnt_r;
   logic          err_r;
   logic [AW-1:0] wr_idx_s;
   logic [AW-1:0] rd_idx_s;
   logic          empty_s;
   logic          full_s;

   // Occupancy flags and slot indices derived from the count.
   always_comb begin
      empty_s  = (cnt_r == CNT_ZERO);
      full_s   = (cnt_r == CNT_FULL);
      wr_idx_s = AW'(cnt_r);
      rd_idx_s = AW'(cnt_r - CNT_ONE);
      if (empty_s) begin
         dout = 3'b000;
      end else begin
         dout = mem_r[rd_idx_s];
      end
   end

   // Storage, count and sticky error; a simultaneous push is ignored in favour of the pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= CNT_ZERO;
         err_r <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 3'b000;
         end
      end else if (pop) begin
         if (empty_s) begin
            err_r <= 1'b1;
         end else begin
            cnt_r <= cnt_r - CNT_ONE;
         end
      end else if (push) begin
         if (full_s) begin
            err_r <= 1'b1;
         end else begin
            mem_r[wr_idx_s] <= din;
            cnt_r           <= cnt_r + CNT_ONE;
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign empty = empty_s;
   assign full  = full_s;
   assign err   = err_r;

endmodule

// File: rtl/ccr_controller.sv
// Execute-stage condition-code register controller: flag merge, jump resolution, interrupt
// freeze FSM and shadow save stack. Define CCR_BYPASS_EN to forward this cycle's flags to jumps.
module ccr_controller
   import alu_ctrl_pkg::*;
#(
   parameter int SHADOW_DEPTH = 2,
   parameter int FREEZE_CYC   = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ex_valid,
   input  logic [3:0] alu_ctrl,
   input  logic [2:0] alu_flag,
   input  logic       br_valid,
   input  logic [1:0] br_type,
   input  logic       int_save,
   input  logic       rti,
   input  logic       flush,
   output logic [2:0] ccr,
   output logic       br_taken,
   output logic       freeze,
   output logic       stk_err
);

   localparam logic [2:0] FREEZE_LOAD = 3'(FREEZE_CYC - 1);

   ccr_state_t state_r, state_nx_s;
   logic [2:0] cnt_r, cnt_nx_s;
   logic [2:0] ccr_r, ccr_nx_s;
   logic [2:0] alu_next_s;
   logic [2:0] eff_s;
   logic [2:0] clr_mask_s;
   logic [1:0] tbit_s;
   logic       upd_ok_s;
   logic       br_go_s;
   logic       br_taken_s;
   logic [2:0] stk_dout_s;
   logic       stk_empty_s;
   logic       stk_full_s;
   logic       stk_err_s;

   ccr_shadow_stack #(.DEPTH(SHADOW_DEPTH)) u_stack (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (int_save),
      .pop   (rti),
      .din   (eff_s),
      .dout  (stk_dout_s),
      .empty (stk_empty_s),
      .full  (stk_full_s),
      .err   (stk_err_s)
   );

   // Flag merge, jump resolution and next CCR with rti > int_save > branch clear > ALU priority.
   always_comb begin
      upd_ok_s = ex_valid & ~flush & (state_r == ST_RUN);
      if (upd_ok_s) begin
         alu_next_s = merge_flags(ccr_r, alu_ctrl, alu_flag);
      end else begin
         alu_next_s = ccr_r;
      end
`ifdef CCR_BYPASS_EN
      eff_s = alu_next_s;
`else
      eff_s = ccr_r;
`endif
      tbit_s  = tested_bit(br_type);
      br_go_s = br_valid & ex_valid & ~flush;
      if (!br_go_s) begin
         br_taken_s = 1'b0;
      end else if (br_type == BR_JMP) begin
         br_taken_s = 1'b1;
      end else begin
         br_taken_s = eff_s[tbit_s];
      end
      // The clear mask is applied after the ALU merge so a clear beats an update of the same bit.
      if (br_taken_s && (br_type != BR_JMP)) begin
         clr_mask_s = 3'b001 << tbit_s;
      end else begin
         clr_mask_s = 3'b000;
      end
      if (rti) begin
         if (!stk_empty_s) begin
            ccr_nx_s = stk_dout_s;
         end else begin
            ccr_nx_s = ccr_r;
         end
      end else if (int_save) begin
         ccr_nx_s = ccr_r;
      end else begin
         ccr_nx_s = alu_next_s & ~clr_mask_s;
      end
   end

   // Freeze FSM next state: rti always returns to RUN, int_save (re)loads the window.
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      if (rti) begin
         state_nx_s = ST_RUN;
         cnt_nx_s   = 3'd0;
      end else if (int_save) begin
         state_nx_s = ST_FREEZE;
         cnt_nx_s   = FREEZE_LOAD;
      end else begin
         case (state_r)
            ST_RUN: begin
               state_nx_s = ST_RUN;
               cnt_nx_s   = 3'd0;
            end
            ST_FREEZE: begin
               if (cnt_r == 3'd0) begin
                  state_nx_s = ST_RUN;
               end else begin
                  cnt_nx_s = cnt_r - 3'd1;
               end
            end
            default: begin
               state_nx_s = ST_RUN;
               cnt_nx_s   = 3'd0;
            end
         endcase
      end
   end

   // State, freeze counter and architectural CCR registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_RUN;
         cnt_r   <= 3'd0;
         ccr_r   <= 3'b000;
      end else begin
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
         ccr_r   <= ccr_nx_s;
      end
   end

   assign ccr      = ccr_r;
   assign br_taken = br_taken_s;
   assign freeze   = (state_r == ST_FREEZE);
   assign stk_err  = stk_err_s;

endmodule
